pulse_train_gen: RTL

//  Parametrised pulse-train generator with a programmable period, high time and pulse count.
//  It also supports a continuous mode, a start/busy/done handshake and a graceful stop.
//  It drives step/clock-style outputs for downstream drivers from the system clock domain.

---
 rtl/pulse_train_gen_if.sv | 39 +++
 rtl/pulse_train_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle for pulse_train_gen.
// The abort/aborted pair exists only when PULSE_ABORT_EN is defined.
interface pulse_train_gen_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
);
    logic             start;
    logic             stop;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] high_len;
    logic [CNT_W-1:0] pulse_num;
    logic             pulse;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] pulse_cnt;
`ifdef PULSE_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    modport master (
`ifdef PULSE_ABORT_EN
        output abort,
        input  aborted,
`endif
        output start, stop, period, high_len, pulse_num,
        input  pulse, busy, done, cfg_err, pulse_cnt
    );

    modport slave (
`ifdef PULSE_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  start, stop, period, high_len, pulse_num,
        output pulse, busy, done, cfg_err, pulse_cnt
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: programmable period/high time/count, continuous mode and graceful stop.
// Optional immediate abort is compiled in when PULSE_ABORT_EN is defined.
module pulse_train_gen #(
    parameter int   CNT_W    = 16,
    parameter int   PER_W    = 16,
    parameter logic IDLE_LVL = 1'b0
) (
    input logic               sysclk,
    input logic               rst,
    pulse_train_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACT   = 2'd1,
        INACT = 2'd2
    } state_t;

    state_t           state_q;
    logic [PER_W-1:0] hi_len_q;
    logic [PER_W-1:0] lo_len_q;
    logic [PER_W-1:0] phase_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stop_pend_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic             cfg_err_q;
`ifdef PULSE_ABORT_EN
    logic             aborted_q;
`endif

    logic             cfg_ok_d;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             finish_d;

    // Start-time config validation and end-of-train decision for the last low cycle.
    always_comb begin
        cfg_ok_d  = (bus.period >= PER_W'(2'd2)) && (bus.high_len != {PER_W{1'b0}})
                    && (bus.high_len < bus.period);
        cnt_inc_d = cnt_q + CNT_W'(1'b1);
        finish_d  = ((num_q != {CNT_W{1'b0}}) && (cnt_inc_d == num_q))
                    || stop_pend_q || bus.stop;
    end

    // Train sequencer; every output is a register updated here.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= IDLE;
            hi_len_q    <= {PER_W{1'b0}};
            lo_len_q    <= {PER_W{1'b0}};
            phase_q     <= PER_W'(1'b1);
            num_q       <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            stop_pend_q <= 1'b0;
            pulse_q     <= IDLE_LVL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef PULSE_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef PULSE_ABORT_EN
            aborted_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.start && cfg_ok_d) begin
                        hi_len_q    <= bus.high_len;
                        lo_len_q    <= bus.period - bus.high_len;
                        num_q       <= bus.pulse_num;
                        cnt_q       <= {CNT_W{1'b0}};
                        phase_q     <= PER_W'(1'b1);
                        stop_pend_q <= 1'b0;
                        state_q     <= ACT;
                        pulse_q     <= ~IDLE_LVL;
                        busy_q      <= 1'b1;
                    end else if (bus.start) begin
                        cfg_err_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACT: begin
                    if (bus.stop) stop_pend_q <= 1'b1;
                    else          stop_pend_q <= stop_pend_q;
                    if (phase_q == hi_len_q) begin
                        phase_q <= PER_W'(1'b1);
                        state_q <= INACT;
                        pulse_q <= IDLE_LVL;
                    end else begin
                        phase_q <= phase_q + PER_W'(1'b1);
                    end
                end
                INACT: begin
                    if (bus.stop) stop_pend_q <= 1'b1;
                    else          stop_pend_q <= stop_pend_q;
                    if (phase_q == lo_len_q) begin
                        // The pulse is complete here; count it before deciding whether to continue.
                        phase_q <= PER_W'(1'b1);
                        cnt_q   <= cnt_inc_d;
                        if (finish_d) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            stop_pend_q <= 1'b0;
                        end else begin
                            state_q <= ACT;
                            pulse_q <= ~IDLE_LVL;
                        end
                    end else begin
                        phase_q <= phase_q + PER_W'(1'b1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pulse_q     <= IDLE_LVL;
                    busy_q      <= 1'b0;
                    stop_pend_q <= 1'b0;
                end
            endcase
`ifdef PULSE_ABORT_EN
            // Abort overrides stop and terminal count; the in-flight pulse is not counted.
            if (bus.abort && (state_q != IDLE)) begin
                state_q     <= IDLE;
                pulse_q     <= IDLE_LVL;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                aborted_q   <= 1'b1;
                stop_pend_q <= 1'b0;
                phase_q     <= PER_W'(1'b1);
                cnt_q       <= cnt_q;
            end
`endif
        end
    end

    assign bus.pulse     = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.pulse_cnt = cnt_q;
`ifdef PULSE_ABORT_EN
    assign bus.aborted   = aborted_q;
`endif
endmodule
